pc_sequencer: RTL

Program-counter and execution sequencer for the A/B-register CPU. It holds the PC that addresses instruction memory and decides each cycle whether the current instruction executes. It latches the ALU status flags and resolves conditional jumps against them. It also provides run, single-step and halt control, and gates the register-load strobes produced by the combinational opcode decoder.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer-facing signal bundle: instruction/decoder inputs, ALU flags, PC and status outputs.
interface pc_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic [6:0]       opcode;
    logic [7:0]       literal;
    logic             flags_we;
    logic             alu_z;
    logic             alu_n;
    logic             alu_c;
    logic             alu_v;
    logic [PC_W-1:0]  pc;
    logic             exec_en;
    logic [3:0]       status;
    logic             jump_taken;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        output run, step, opcode, literal, flags_we, alu_z, alu_n, alu_c, alu_v,
        input  pc, exec_en, status, jump_taken, halted, retired
    );

    modport slave (
        input  run, step, opcode, literal, flags_we, alu_z, alu_n, alu_c, alu_v,
        output pc, exec_en, status, jump_taken, halted, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC and execution sequencer: IDLE/RUN/HALT control, latched ALU flags, conditional jumps.
// exec_en/jump_taken are combinational; pc, status, retired and state update on the ending edge.
module pc_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [6:0] OP_HALT = 7'b1111111;
    localparam logic [6:0] OP_JMP  = 7'b1001101;
    localparam logic [6:0] OP_JEQ  = 7'b1001110;
    localparam logic [6:0] OP_JNE  = 7'b1001111;
    localparam logic [6:0] OP_JGT  = 7'b1010000;
    localparam logic [6:0] OP_JLT  = 7'b1010001;
    localparam logic [6:0] OP_JGE  = 7'b1010010;
    localparam logic [6:0] OP_JLE  = 7'b1010011;
    localparam logic [6:0] OP_JCR  = 7'b1010100;
    localparam logic [6:0] OP_JOV  = 7'b1010101;

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic [3:0]       status;
    logic [CNT_W-1:0] retired;
    logic             halted;
    logic             exec_en;
    logic             cond_true;
    logic             jump_taken;

    wire st_z = status[0];
    wire st_n = status[1];
    wire st_c = status[2];
    wire st_v = status[3];

    // Reset wins over step, so an executing cycle never coincides with rst.
    assign exec_en = ~rst & ((state == RUN) | ((state == IDLE) & bus.step));

    // Conditions look only at latched status so a flag write lands before the next jump.
    always_comb begin
        cond_true = 1'b0;
        case (bus.opcode)
            OP_JMP:  cond_true = 1'b1;
            OP_JEQ:  cond_true = st_z;
            OP_JNE:  cond_true = ~st_z;
            OP_JGT:  cond_true = ~st_z & ~st_n;
            OP_JLT:  cond_true = st_n;
            OP_JGE:  cond_true = ~st_n;
            OP_JLE:  cond_true = st_z | st_n;
            OP_JCR:  cond_true = st_c;
            OP_JOV:  cond_true = st_v;
            default: cond_true = 1'b0;
        endcase
    end

    assign jump_taken = exec_en & cond_true;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            status  <= '0;
            retired <= '0;
            halted  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (bus.run)  state <= RUN;
                RUN:     if (!bus.run) state <= IDLE;
                default: state <= HALT;
            endcase
            if (exec_en) begin
                if (bus.flags_we)
                    status <= {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z};
                if (retired != {CNT_W{1'b1}})
                    retired <= retired + CNT_W'(1);
                if (bus.opcode == OP_HALT) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else if (jump_taken) begin
                    pc <= bus.literal[PC_W-1:0];
                end else begin
                    pc <= pc + PC_W'(1);
                end
            end
        end
    end

    assign bus.pc         = pc;
    assign bus.exec_en    = exec_en;
    assign bus.status     = status;
    assign bus.jump_taken = jump_taken;
    assign bus.halted     = halted;
    assign bus.retired    = retired;
endmodule
